// File: rtl/jt89_wrfifo.sv
// jt89_wrfifo: CPU-side write FIFO that replays bytes to a jt89 PSG core.
// Macro JT89_WRFIFO_TIMEOUT_EN adds a WAIT_RDY watchdog that sets tmo.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_wr, cpu_din       one-cycle push strobe and byte
//   cpu_full, cpu_empty   FIFO status (registered)
//   cpu_level             entry count, 0..2**AW
//   ovf, ovf_clr          sticky dropped-push flag and its clear
//   tmo                   sticky watchdog flag (0 without the macro)
//   psg_din/cs_n/wr_n     write bus towards jt89
//   psg_ready             jt89 ready
module jt89_wrfifo #(
  parameter int AW         = 3,
  parameter int STROBE_LEN = 2,
  parameter int TMO_CYC    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_full,
  output logic        cpu_empty,
  output logic [AW:0] cpu_level,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic        tmo,
  output logic [7:0]  psg_din,
  output logic        psg_cs_n,
  output logic        psg_wr_n,
  input  logic        psg_ready
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [3:0]  SLEN = 4'(STROBE_LEN);

  if (STROBE_LEN < 2 || STROBE_LEN > 15) begin : g_bad_strobe
    $error("jt89_wrfifo: STROBE_LEN out of range 2..15");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
    $error("jt89_wrfifo: TMO_CYC out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_RDY
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_nxt;
  state_t        state;
  state_t        state_nxt;
  logic [3:0]    scnt;
  logic [3:0]    scnt_nxt;
  logic          cs_nxt;
  logic [7:0]    din_nxt;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          wait_enter;
  logic          tmo_hit;

  // Full is the registered flag, so a same-cycle pop cannot rescue a push.
  always_comb begin
    push_ok = cpu_wr & ~cpu_full;
    drop    = cpu_wr & cpu_full;
  end

  always_comb begin
    level_nxt = cpu_level;
    unique case ({push_ok, pop})
      2'b10:   level_nxt = cpu_level + 1'b1;
      2'b01:   level_nxt = cpu_level - 1'b1;
      default: level_nxt = cpu_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cpu_level <= '0;
      cpu_full  <= 1'b0;
      cpu_empty <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cpu_level <= level_nxt;
      cpu_full  <= (level_nxt == FULL_LVL);
      cpu_empty <= (level_nxt == '0);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // scnt counts low cycles; entry from IDLE is the first one.
  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    cs_nxt     = psg_cs_n;
    din_nxt    = psg_din;
    pop        = 1'b0;
    wait_enter = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cpu_empty && psg_ready) begin
          pop       = 1'b1;
          din_nxt   = mem[rd_ptr];
          cs_nxt    = 1'b0;
          scnt_nxt  = 4'd1;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (scnt == SLEN) begin
          cs_nxt     = 1'b1;
          wait_enter = 1'b1;
          state_nxt  = WAIT_RDY;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (psg_ready || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      scnt     <= '0;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      psg_din  <= '0;
    end else begin
      state    <= state_nxt;
      scnt     <= scnt_nxt;
      psg_cs_n <= cs_nxt;
      psg_wr_n <= cs_nxt;
      psg_din  <= din_nxt;
    end
  end

`ifdef JT89_WRFIFO_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TMO_CYC - 1);

  logic [7:0] tcnt;

  // tcnt is 0 in the first WAIT_RDY cycle, so the hit
  // lands at the end of the TMO_CYC-th waiting cycle.
  always_comb begin
    tmo_hit = (state == WAIT_RDY) && !psg_ready
            && (tcnt == TLIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      if (wait_enter)             tcnt <= '0;
      else if (state == WAIT_RDY) tcnt <= tcnt + 1'b1;
      if (tmo_hit) tmo <= 1'b1;
    end
  end
`else
  always_comb tmo_hit = 1'b0;
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_jt89_wrfifo.sv
// tb_jt89_wrfifo: directed bench for jt89_wrfifo with a small PSG model.
// Define JT89_WRFIFO_TIMEOUT_EN to exercise the watchdog build.
module tb_jt89_wrfifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_din = '0;
  logic       cpu_full;
  logic       cpu_empty;
  logic [3:0] cpu_level;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       tmo;
  logic [7:0] psg_din;
  logic       psg_cs_n;
  logic       psg_wr_n;
  logic       psg_ready;
  logic       ready_en = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jt89_wrfifo #(
    .AW(3),
    .STROBE_LEN(2),
    .TMO_CYC(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_wr(cpu_wr),
    .cpu_din(cpu_din),
    .cpu_full(cpu_full),
    .cpu_empty(cpu_empty),
    .cpu_level(cpu_level),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .tmo(tmo),
    .psg_din(psg_din),
    .psg_cs_n(psg_cs_n),
    .psg_wr_n(psg_wr_n),
    .psg_ready(psg_ready)
  );

  // PSG model: busy for 31 cycles after each cs_n falling edge.
  logic       cs_prev = 1'b1;
  int         psg_busy = 0;
  int         low_cnt = 0;
  int         last_len = 0;
  int         viol = 0;
  logic [7:0] rx[$];

  assign psg_ready = ready_en && (psg_busy == 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      cs_prev  <= 1'b1;
      psg_busy <= 0;
      low_cnt  <= 0;
    end else begin
      cs_prev <= psg_cs_n;
      if (!psg_cs_n && cs_prev) begin
        rx.push_back(psg_din);
        if (psg_busy != 0) viol <= viol + 1;
        psg_busy <= 31;
      end else if (psg_busy > 0) begin
        psg_busy <= psg_busy - 1;
      end
      if (!psg_cs_n) low_cnt <= low_cnt + 1;
      else if (!cs_prev) begin
        last_len <= low_cnt;
        low_cnt  <= 0;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    cpu_wr  = 1'b1;
    cpu_din = b;
    cyc(1);
    cpu_wr  = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int base,
                         input int n, input int max);
    int k = 0;
    while (rx.size() < base + n && k < max) begin
      cyc(1);
      k++;
    end
    chk(tag, rx.size() - base, n);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int k = 0;
    while (!(cpu_empty && psg_cs_n && psg_busy == 0) && k < max) begin
      cyc(1);
      k++;
    end
    cyc(2);
    chk(tag, int'(k < max), 1);
  endtask

  initial begin
    int base;

    // reset
    rst_n = 1'b0;
    cyc(3);
    chk("rst_cs_n", psg_cs_n, 1);
    chk("rst_wr_n", psg_wr_n, 1);
    chk("rst_din", psg_din, 0);
    chk("rst_level", cpu_level, 0);
    chk("rst_empty", cpu_empty, 1);
    chk("rst_full", cpu_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    rst_n = 1'b1;
    cyc(1);

    // single write, strobe shape, then ready gating
    base = rx.size();
    push(8'h9F);
    chk("w1_level_push", cpu_level, 1);
    cyc(1);
    chk("w1_cs_low", psg_cs_n, 0);
    chk("w1_wr_low", psg_wr_n, 0);
    chk("w1_din", psg_din, 8'h9F);
    chk("w1_level_pop", cpu_level, 0);
    cyc(1);
    chk("w1_cs_hold", psg_cs_n, 0);
    cyc(1);
    chk("w1_cs_rel", psg_cs_n, 1);
    chk("w1_wr_rel", psg_wr_n, 1);
    push(8'h11);
    push(8'h22);
    chk("w1_len", last_len, 2);
    cyc(5);
    chk("busy_cs_high", psg_cs_n, 1);
    chk("busy_level", cpu_level, 2);
    chk("busy_din_keep", psg_din, 8'h9F);
    wait_rx("w1_rx_cnt", base, 3, 400);
    wait_drain("w1_drain", 400);
    chk("w1_rx0", rx[base], 8'h9F);
    chk("w1_rx1", rx[base+1], 8'h11);
    chk("w1_rx2", rx[base+2], 8'h22);
    chk("w1_len2", last_len, 2);
    chk("w1_ready_viol", viol, 0);

    // burst of 9 with ready low
    base = rx.size();
    ready_en = 1'b0;
    cpu_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cpu_din = 8'hA0 + 8'(i);
      cyc(1);
    end
    cpu_wr = 1'b0;
    chk("burst_level", cpu_level, 8);
    chk("burst_full", cpu_full, 1);
    chk("burst_ovf", ovf, 1);
    chk("burst_none", rx.size() - base, 0);
    ready_en = 1'b1;
    wait_rx("burst_rx_cnt", base, 8, 1500);
    wait_drain("burst_drain", 400);
    cyc(60);
    chk("burst_no9th", rx.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_rx%0d", i), rx[base+i], 8'hA0 + i);
    chk("burst_ovf_sticky", ovf, 1);

    // full + simultaneous pop and push
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    base = rx.size();
    ready_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    chk("fp_full", cpu_full, 1);
    ready_en = 1'b1;
    cpu_wr = 1'b1;
    cpu_din = 8'h55;
    cyc(1);
    cpu_wr = 1'b0;
    chk("fp_level", cpu_level, 7);
    chk("fp_ovf", ovf, 1);
    chk("fp_full_after", cpu_full, 0);
    chk("fp_cs_low", psg_cs_n, 0);
    wait_rx("fp_rx_cnt", base, 8, 1500);
    wait_drain("fp_drain", 400);
    chk("fp_no55", rx.size() - base, 8);
    chk("fp_rx7", rx[base+7], 8'hB7);

    // ovf_clr with push: clear while not full, set wins while full
    base = rx.size();
    ready_en = 1'b0;
    cpu_wr = 1'b1;
    cpu_din = 8'h66;
    ovf_clr = 1'b1;
    cyc(1);
    cpu_wr = 1'b0;
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_level", cpu_level, 1);
    for (int i = 1; i < 8; i++) push(8'h66 + 8'(i));
    cpu_wr = 1'b1;
    cpu_din = 8'hEE;
    ovf_clr = 1'b1;
    cyc(1);
    cpu_wr = 1'b0;
    ovf_clr = 1'b0;
    chk("setwin_ovf", ovf, 1);
    chk("setwin_level", cpu_level, 8);
    ready_en = 1'b1;
    wait_rx("clr_rx_cnt", base, 8, 1500);
    wait_drain("clr_drain", 400);
    chk("clr_rx0", rx[base], 8'h66);
    chk("clr_rx7", rx[base+7], 8'h6D);

    // reset during strobe
    push(8'h77);
    cyc(1);
    chk("rs_cs_low", psg_cs_n, 0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("rs_cs_n", psg_cs_n, 1);
    chk("rs_wr_n", psg_wr_n, 1);
    chk("rs_empty", cpu_empty, 1);
    chk("rs_level", cpu_level, 0);
    chk("rs_ovf", ovf, 0);
    base = rx.size();
    push(8'h80);
    wait_rx("rs_rx_cnt", base, 1, 50);
    wait_drain("rs_drain", 400);
    chk("rs_rx0", rx[base], 8'h80);
    chk("rs_len", last_len, 2);
    chk("rs_only1", rx.size() - base, 1);

    // ready stuck low after a write
    base = rx.size();
    push(8'h33);
    cyc(1);
    ready_en = 1'b0;
`ifdef JT89_WRFIFO_TIMEOUT_EN
    cyc(21);
    chk("tmo_early", tmo, 0);
    cyc(1);
    chk("tmo_set", tmo, 1);
`else
    cyc(40);
    chk("tmo_off", tmo, 0);
`endif
    chk("tmo_cs_n", psg_cs_n, 1);
    push(8'h44);
    cyc(10);
    chk("tmo_hold_level", cpu_level, 1);
    chk("tmo_hold_cs", psg_cs_n, 1);
    ready_en = 1'b1;
    wait_rx("tmo_rx_cnt", base, 2, 200);
    wait_drain("tmo_drain", 400);
    chk("tmo_rx1", rx[base+1], 8'h44);
`ifdef JT89_WRFIFO_TIMEOUT_EN
    chk("tmo_sticky", tmo, 1);
`else
    chk("tmo_still0", tmo, 0);
`endif
    chk("final_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
